redmule_castout_packer: RTL and testbench

Output packing stage placed directly downstream of the RedMulE output cast unit and upstream of the Z-store streamer. When the cast narrows elements, only the low half of each cast word is meaningful. This block compacts `Ratio` consecutive narrow cast words into one full memory word with a byte strobe, and passes wide (uncast) words through unchanged. All traffic uses valid/ready handshakes; partial words are flushed on `last`, on a mode change, or discarded on `clear_i`.

---
 rtl/redmule_pkg.sv | 13 +
 rtl/redmule_castout_packer.sv | 102 ++++++++++
 tb/tb_redmule_castout_packer.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/redmule_pkg.sv
// Shared RedMulE constants and types used by the output cast/pack path.
package redmule_pkg;

  localparam int unsigned DW_CUT             = 256;
  localparam int unsigned CASTOUT_PACK_RATIO = 2;

  typedef struct packed {
    logic [DW_CUT-1:0]   data;
    logic [DW_CUT/8-1:0] strb;
    logic                last;
  } castout_beat_t;

endpackage

// File: rtl/redmule_castout_packer.sv
// Packs Ratio narrow cast words into one strobed memory word; wide words pass through.
// Handshake: a beat transfers on a rising edge where valid && ready; valid never waits on ready.
module redmule_castout_packer
  import redmule_pkg::*;
#(
  parameter int unsigned DataW = DW_CUT,
  parameter int unsigned Ratio = CASTOUT_PACK_RATIO
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               clear_i,
  input  logic               in_valid_i,
  output logic               in_ready_o,
  input  logic [DataW-1:0]   in_data_i,
  input  logic               in_narrow_i,
  input  logic               in_last_i,
  output logic               out_valid_o,
  input  logic               out_ready_i,
  output logic [DataW-1:0]   out_data_o,
  output logic [DataW/8-1:0] out_strb_o,
  output logic               out_last_o
);

  localparam int unsigned NarrowW = DataW / Ratio;
  localparam int unsigned StrbW   = DataW / 8;
  localparam int unsigned SliceB  = StrbW / Ratio;
  localparam int unsigned CntW    = (Ratio > 1) ? $clog2(Ratio) : 1;

  logic [DataW-1:0] r_data;
  logic [StrbW-1:0] r_strb;
  logic             r_last;
  logic             r_out_valid;
  logic [CntW-1:0]  r_cnt;

  logic             w_flush_needed;
  logic             w_out_free;
  logic             w_in_fire;
  logic             w_word_done;
  logic [DataW-1:0] w_pack_data;
  logic [StrbW-1:0] w_pack_strb;

  // While a partial word is being filled the register is never valid, so a
  // wide beat can always promote it immediately; the wide beat waits one cycle.
  assign w_flush_needed = (r_cnt != '0) && !in_narrow_i && in_valid_i;
  assign w_out_free     = !r_out_valid || out_ready_i;
  assign in_ready_o     = w_out_free && !w_flush_needed;
  assign w_in_fire      = in_valid_i && in_ready_o;
  assign w_word_done    = (r_cnt == CntW'(Ratio - 1)) || in_last_i;

  always_comb begin
    w_pack_data = (r_cnt == '0) ? '0 : r_data;
    w_pack_strb = (r_cnt == '0) ? '0 : r_strb;
    for (int s = 0; s < int'(Ratio); s++) begin
      if (CntW'(s) == r_cnt) begin
        w_pack_data[s*NarrowW +: NarrowW] = in_data_i[NarrowW-1:0];
        w_pack_strb[s*SliceB +: SliceB]   = '1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      r_data      <= '0;
      r_strb      <= '0;
      r_last      <= 1'b0;
      r_out_valid <= 1'b0;
      r_cnt       <= '0;
    end else begin
      if (r_out_valid && out_ready_i) begin
        r_out_valid <= 1'b0;
      end
      if (w_flush_needed) begin
        r_out_valid <= 1'b1;
        r_last      <= 1'b0;
        r_cnt       <= '0;
      end else if (w_in_fire) begin
        if (in_narrow_i) begin
          r_data <= w_pack_data;
          r_strb <= w_pack_strb;
          if (w_word_done) begin
            r_out_valid <= 1'b1;
            r_last      <= in_last_i;
            r_cnt       <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end else begin
          r_data      <= in_data_i;
          r_strb      <= '1;
          r_last      <= in_last_i;
          r_out_valid <= 1'b1;
        end
      end
    end
  end

  assign out_valid_o = r_out_valid;
  assign out_data_o  = r_data;
  assign out_strb_o  = r_strb;
  assign out_last_o  = r_last;

endmodule

// File: tb/tb_redmule_castout_packer.sv
// Directed bench for redmule_castout_packer with a packing model feeding an expected-word queue.
module tb_redmule_castout_packer;

  localparam int DW = 256;
  localparam int SW = DW / 8;
  localparam int EW = DW + SW + 1;
  localparam int HW = DW / 2;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_i = 1'b1;
  logic          clear_i = 1'b0;
  logic          in_valid_i = 1'b0;
  logic          in_ready_o;
  logic [DW-1:0] in_data_i = '0;
  logic          in_narrow_i = 1'b0;
  logic          in_last_i = 1'b0;
  logic          out_valid_o;
  logic          out_ready_i = 1'b1;
  logic [DW-1:0] out_data_o;
  logic [SW-1:0] out_strb_o;
  logic          out_last_o;

  redmule_castout_packer dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .clear_i     (clear_i),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .in_data_i   (in_data_i),
    .in_narrow_i (in_narrow_i),
    .in_last_i   (in_last_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .out_data_o  (out_data_o),
    .out_strb_o  (out_strb_o),
    .out_last_o  (out_last_o)
  );

  int checks = 0;
  int errors = 0;
  logic [EW-1:0] exp_q[$];

  // packing model
  int            m_cnt = 0;
  logic [DW-1:0] m_data = '0;
  logic [SW-1:0] m_strb = '0;

  function automatic logic [DW-1:0] rand256();
    logic [DW-1:0] v;
    for (int i = 0; i < DW / 32; i++) v[i*32 +: 32] = $urandom();
    return v;
  endfunction

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_beat(input logic [DW-1:0] d, input logic nar, input logic lst);
    if (nar) begin
      if (m_cnt == 0) begin
        m_data = '0;
        m_strb = '0;
      end
      m_data[m_cnt*HW +: HW] = d[HW-1:0];
      m_strb[m_cnt*(SW/2) +: SW/2] = '1;
      if (m_cnt == 1 || lst) begin
        exp_q.push_back({m_data, m_strb, lst});
        m_cnt = 0;
      end else begin
        m_cnt = 1;
      end
    end else begin
      if (m_cnt != 0) begin
        exp_q.push_back({m_data, m_strb, 1'b0});
        m_cnt = 0;
      end
      exp_q.push_back({d, {SW{1'b1}}, lst});
    end
  endtask

  // driver: presents one beat, returns how many cycles in_ready_o was low
  task automatic send(input logic [DW-1:0] d, input logic nar, input logic lst,
                      output int waits);
    in_valid_i  = 1'b1;
    in_data_i   = d;
    in_narrow_i = nar;
    in_last_i   = lst;
    model_beat(d, nar, lst);
    waits = 0;
    @(negedge clk);
    while (!in_ready_o && waits < 20) begin
      @(negedge clk);
      waits++;
    end
    if (waits >= 20) begin
      checks++;
      errors++;
      $error("FAIL send_timeout observed=%0d expected<20", waits);
    end
    @(posedge clk);
    #1;
    in_valid_i = 1'b0;
  endtask

  // scoreboard / monitor
  always @(negedge clk) begin
    if (!rst_i && out_valid_o && out_ready_i) begin
      checks++;
      assert (exp_q.size() != 0) else begin
        errors++;
        $error("FAIL unexpected_out observed=%h expected=none", {out_data_o, out_strb_o, out_last_o});
      end
      if (exp_q.size() != 0) begin
        logic [EW-1:0] e;
        e = exp_q.pop_front();
        checks++;
        assert ({out_data_o, out_strb_o, out_last_o} === e) else begin
          errors++;
          $error("FAIL out_word observed=%h expected=%h", {out_data_o, out_strb_o, out_last_o}, e);
        end
      end
    end
  end

  initial begin
    int w;
    int wsum;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic [DW-1:0] x;

    repeat (3) @(posedge clk);
    #1 rst_i = 1'b0;
    @(negedge clk);
    check_bit("rst_out_valid", out_valid_o, 1'b0);
    check_bit("rst_data_zero", out_data_o == '0, 1'b1);
    check_bit("rst_strb_zero", out_strb_o == '0, 1'b1);
    check_bit("rst_out_last", out_last_o, 1'b0);
    check_bit("rst_in_ready", in_ready_o, 1'b1);
    @(posedge clk); #1;

    // narrow pairing, upper halves carry junk that must not leak
    a = {rand256() >> HW, {(HW/16){16'hAAAA}}};
    a[DW-1:HW] = rand256() >> HW;
    b = {{(HW/16){16'h5555}}, {(HW/16){16'hBBBB}}};
    send(a, 1'b1, 1'b0, w);
    send(b, 1'b1, 1'b0, w);
    check_bit("pair_latency_valid", out_valid_o, 1'b1);
    check_bit("pair_strb_full", out_strb_o == {SW{1'b1}}, 1'b1);
    @(posedge clk); #1;

    // odd narrow tile
    send(rand256(), 1'b1, 1'b0, w);
    send(rand256(), 1'b1, 1'b0, w);
    send(rand256(), 1'b1, 1'b1, w);
    check_bit("odd_tail_last", out_last_o, 1'b1);
    check_bit("odd_tail_strb_half", out_strb_o == {{(SW/2){1'b0}}, {(SW/2){1'b1}}}, 1'b1);
    @(posedge clk); #1;

    // wide pass-through, back to back
    wsum = 0;
    for (int i = 0; i < 8; i++) begin
      send(rand256(), 1'b0, (i == 7), w);
      wsum += w;
    end
    check_int("wide_ready_stalls", wsum, 0);
    @(posedge clk); #1;

    // mode change: narrow then wide costs one bubble
    x = rand256();
    send(x, 1'b1, 1'b0, w);
    send(rand256(), 1'b0, 1'b1, w);
    check_int("mode_change_bubble", w, 1);
    @(posedge clk); #1;

    // backpressure with a complete word pending
    out_ready_i = 1'b0;
    send(rand256(), 1'b1, 1'b0, w);
    send(rand256(), 1'b1, 1'b0, w);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_bit("bp_valid_held", out_valid_o, 1'b1);
      check_bit("bp_word_stable", {out_data_o, out_strb_o, out_last_o} === exp_q[0], 1'b1);
      check_bit("bp_in_ready_low", in_ready_o, 1'b0);
    end
    @(posedge clk); #1;
    out_ready_i = 1'b1;
    send(rand256(), 1'b0, 1'b0, w);
    check_int("bp_release_same_cycle", w, 0);
    @(posedge clk); #1;

    // clear mid-word drops the partial slice
    in_valid_i  = 1'b1;
    in_narrow_i = 1'b1;
    in_last_i   = 1'b0;
    in_data_i   = {(DW/16){16'hDEAD}};
    @(posedge clk); #1;
    in_valid_i = 1'b0;
    clear_i    = 1'b1;
    @(posedge clk); #1;
    clear_i = 1'b0;
    m_cnt   = 0;
    @(negedge clk);
    check_bit("clear_no_output", out_valid_o, 1'b0);
    @(posedge clk); #1;
    send(rand256(), 1'b1, 1'b0, w);
    send(rand256(), 1'b1, 1'b1, w);

    // drain
    w = 0;
    while (exp_q.size() != 0 && w < 50) begin
      @(negedge clk);
      w++;
    end
    check_int("queue_drained", exp_q.size(), 0);
    repeat (3) @(negedge clk);
    check_bit("idle_no_valid", out_valid_o, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
